// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/ack and decode valid/ready.
// master = fetch unit side, slave = memory/decode/redirect source side.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    modport master (
        input  redirect_valid, redirect_addr, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, fault
    );

    modport slave (
        output redirect_valid, redirect_addr, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding word fetch, single-entry
// output holding register toward decode, and redirect/fault handling.

module mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

// state | meaning
// START | one idle cycle after reset; redirect may still be applied
// FETCH | mem_req high at pc, waiting for mem_ack
// HOLD  | instruction presented to decode, waiting for out_ready
// FAULT | misaligned redirect seen; parked until an aligned redirect
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {START, FETCH, HOLD, FAULT} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        target_misaligned;

    logic        pc_load;
    logic        use_target;
    logic        pend_set;
    logic        pend_clr;
    logic        out_load;

    assign pc_plus4 = pc + 32'd4;

    // A same-cycle redirect always beats a pending one (newest wins).
    mux2 #(.W(32)) u_target_mux (
        .sel (bus.redirect_valid),
        .a   (pend_addr),
        .b   (bus.redirect_addr),
        .y   (target)
    );

    mux2 #(.W(32)) u_pc_mux (
        .sel (use_target),
        .a   (pc_plus4),
        .b   (target),
        .y   (pc_next)
    );

    assign target_misaligned = (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_load       = 1'b0;
        use_target    = 1'b0;
        pend_set      = 1'b0;
        pend_clr      = 1'b0;
        out_load      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.out_valid = 1'b0;
        bus.fault     = 1'b0;
        bus.mem_addr  = {pc[31:2], 2'b00};
        bus.out_instr = instr_q;
        bus.out_pc    = instr_pc_q;

        unique case (state)
            START: begin
                // Any mem_ack here belongs to a request abandoned by reset.
                if (bus.redirect_valid) begin
                    if (target_misaligned) begin
                        state_next = FAULT;
                    end else begin
                        pc_load    = 1'b1;
                        use_target = 1'b1;
                        state_next = FETCH;
                    end
                end else begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    pend_clr = 1'b1;
                    if (bus.redirect_valid || pend_valid) begin
                        if (target_misaligned) begin
                            state_next = FAULT;
                        end else begin
                            pc_load    = 1'b1;
                            use_target = 1'b1;
                        end
                    end else begin
                        out_load   = 1'b1;
                        pc_load    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pend_set = 1'b1;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.redirect_valid) begin
                    if (target_misaligned) begin
                        state_next = FAULT;
                    end else begin
                        pc_load    = 1'b1;
                        use_target = 1'b1;
                        state_next = FETCH;
                    end
                end else if (bus.out_ready) begin
                    state_next = FETCH;
                end
            end
            FAULT: begin
                bus.fault = 1'b1;
                if (bus.redirect_valid && !target_misaligned) begin
                    pc_load    = 1'b1;
                    use_target = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            pend_valid <= 1'b0;
            pend_addr  <= 32'h0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            if (pc_load) begin
                pc <= pc_next;
            end
            if (pend_clr) begin
                pend_valid <= 1'b0;
            end else if (pend_set) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.redirect_addr;
            end
            if (out_load) begin
                instr_q    <= bus.mem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

`ifdef FORMAL
    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.mem_req && !bus.mem_ack) |=> $stable(bus.mem_addr));
    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_instr) && $stable(bus.out_pc)));
    a_fault_quiet: assert property (@(posedge clk) disable iff (reset)
        bus.fault |-> (!bus.mem_req && !bus.out_valid));
    a_req_xor_valid: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_req && bus.out_valid));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus hand-written
// sequences for wraparound, reset mid-fetch, stale ack and pending misaligned redirect.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] ra;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D0 = 32'hA000_0000, D1 = 32'hA111_1111, D2 = 32'hA222_2222;
    localparam logic [31:0] D3 = 32'hA333_3333, D4 = 32'hA444_4444, D5 = 32'hA555_5555;
    localparam logic [31:0] D6 = 32'hA666_6666, D7 = 32'hA777_7777, D8 = 32'hA888_8888;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    function automatic void add(input logic rst, input logic rv, input logic [31:0] ra,
                                input logic ack, input logic [31:0] rd, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic e_fault);
        vec_t v;
        v.rst = rst; v.rv = rv; v.ra = ra; v.ack = ack; v.rd = rd; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_fault = e_fault;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic rv, input logic [31:0] ra,
                         input logic ack, input logic [31:0] rd, input logic rdy);
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.mem_ack        = ack;
        bus.mem_rdata      = rd;
        bus.out_ready      = rdy;
    endtask

    // mem_addr is only meaningful while requesting, out_* only while valid.
    task automatic chk(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic e_fault);
        logic ok;
        ok = (bus.mem_req === e_req) && (bus.out_valid === e_valid) && (bus.fault === e_fault);
        if (e_req) ok = ok && (bus.mem_addr === e_addr);
        if (e_valid) ok = ok && (bus.out_instr === e_instr) && (bus.out_pc === e_pc);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h fault=%b; want req=%b addr=%h valid=%b instr=%h pc=%h fault=%b",
                     name, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_instr, bus.out_pc, bus.fault,
                     e_req, e_addr, e_valid, e_instr, e_pc, e_fault);
        end
    endtask

    initial begin
        //   rst rv ra            ack rd   rdy | req addr          vld instr pc            flt
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        0, 0,  32'h0,        0); // reset state
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h0,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, D0,  1,    1, 32'h0,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D0, 32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h4,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, D1,  1,    1, 32'h4,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D1, 32'h4,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h8,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, D2,  1,    1, 32'h8,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D2, 32'h8,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'hC,        0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, D3,  1,    1, 32'hC,        0, 0,  32'h0,        0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 32'h0,    0, 0,   0,    0, 32'h0,        1, D3, 32'hC,        0); // stalled
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D3, 32'hC,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h10,       0, 0,  32'h0,        0);
        add(0, 1, 32'h100,      0, 0,   1,    1, 32'h10,       0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h10,       0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h10,       0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, BAD, 1,    1, 32'h10,       0, 0,  32'h0,        0);
        add(0, 1, 32'h200,      0, 0,   1,    1, 32'h100,      0, 0,  32'h0,        0);
        add(0, 1, 32'h300,      0, 0,   1,    1, 32'h100,      0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, BAD, 1,    1, 32'h100,      0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h300,      0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        1, D4,  1,    1, 32'h300,      0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D4, 32'h300,      0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h304,      0, 0,  32'h0,        0);
        add(0, 1, 32'h40,       1, BAD, 1,    1, 32'h304,      0, 0,  32'h0,        0); // redirect with ack
        add(0, 0, 32'h0,        1, D5,  1,    1, 32'h40,       0, 0,  32'h0,        0);
        add(0, 1, 32'h102,      0, 0,   0,    0, 32'h0,        1, D5, 32'h40,       0);
        add(0, 1, 32'h106,      0, 0,   1,    0, 32'h0,        0, 0,  32'h0,        1);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        0, 0,  32'h0,        1);
        add(0, 1, 32'h80,       0, 0,   1,    0, 32'h0,        0, 0,  32'h0,        1);
        add(0, 0, 32'h0,        1, D6,  1,    1, 32'h80,       0, 0,  32'h0,        0);
        add(0, 0, 32'h0,        0, 0,   1,    0, 32'h0,        1, D6, 32'h80,       0);
        add(0, 0, 32'h0,        0, 0,   1,    1, 32'h84,       0, 0,  32'h0,        0);

        drive(1, 0, 32'h0, 0, 32'h0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_fault);
            drive(vecs[i].rst, vecs[i].rv, vecs[i].ra, vecs[i].ack, vecs[i].rd, vecs[i].rdy);
            @(negedge clk);
        end

        // Redirect to the top word, then wrap past 2^32.
        chk("pre_wrap", 1, 32'h84, 0, 0, 0, 0);
        drive(0, 1, 32'hFFFF_FFFC, 1, BAD, 1);
        @(negedge clk);
        chk("top_req", 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 1, D7, 1);
        @(negedge clk);
        chk("top_out", 0, 0, 1, D7, 32'hFFFF_FFFC, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        chk("wrap_req", 1, 32'h0, 0, 0, 0, 0);

        // Reset mid-FETCH, then a stale ack in START must be ignored.
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        chk("reset_mid", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 1, BAD, 1);
        @(negedge clk);
        chk("stale_ack1", 1, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        chk("stale_ack2", 1, 32'h0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 1, D8, 1);
        @(negedge clk);
        chk("restart_out", 0, 0, 1, D8, 32'h0, 0);

        // Reset clears the output registers; redirect in START; pending misaligned target faults on ack.
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        chk("reset2", 0, 0, 0, 0, 0, 0);
        tests++;
        if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_out: got instr=%h pc=%h; want 0 0", bus.out_instr, bus.out_pc);
        end
        drive(0, 1, 32'h500, 0, 32'h0, 1);
        @(negedge clk);
        chk("start_redirect", 1, 32'h500, 0, 0, 0, 0);
        drive(0, 1, 32'h507, 0, 32'h0, 1);
        @(negedge clk);
        chk("pend_misaligned", 1, 32'h500, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 1, BAD, 1);
        @(negedge clk);
        chk("pend_fault", 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
